data_mem_responder: RTL and testbench

//  Responder end of the core's data-memory interface (daddr/ddata_w/ddata_r/d_w/d_r).

---
 rtl/dmem_pkg.sv | 32 +++
 rtl/dmem_ram.sv | 32 +++
 rtl/data_mem_responder.sv | 150 +++++++++++++++
 tb/tb_data_mem_responder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_pkg
//  Purpose  : Shared constants for the data-memory responder: region nibbles,
//             peripheral register offsets and STATUS/CTRL bit positions.
//  Revision : 1.0  initial release
// ============================================================================
package dmem_pkg;

  // Default address-region selectors, compared against daddr[31:28]
  localparam logic [3:0] RAM_REGION    = 4'h0;
  localparam logic [3:0] PERIPH_REGION = 4'h8;

  // Peripheral register word offsets (daddr[4:2]); 5..7 are unimplemented
  typedef enum logic [2:0] {
    REG_GPIO_OUT = 3'd0,
    REG_CNT      = 3'd1,
    REG_CMP      = 3'd2,
    REG_STATUS   = 3'd3,
    REG_CTRL     = 3'd4
  } periph_reg_e;

  // STATUS register bits (sticky, write-1-to-clear)
  localparam int STATUS_MATCH_BIT = 0;
  localparam int STATUS_ERR_BIT   = 1;

  // CTRL register bits
  localparam int CTRL_EN_BIT = 0;
  localparam int CTRL_IE_BIT = 1;

endpackage
`default_nettype wire

// File: rtl/dmem_ram.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_ram
//  Purpose  : Word-organised data RAM, asynchronous read, synchronous write.
//             Contents are deliberately not reset.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_ram #(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [WORDS];

  // Commit one word per cycle while the write enable is high
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read returns the pre-edge contents, so a same-cycle read sees old data
  assign rdata_o = mem_q[addr_i];

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_responder
//  Purpose  : Responder side of the core data-memory bus. Decodes accesses to
//             the RAM or the peripheral block (GPIO, compare timer, status).
//  Revision : 1.0  initial release
// ============================================================================
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int          RAM_WORDS   = 1024,
  parameter logic [31:0] RAM_BASE    = {RAM_REGION, 28'h0},
  parameter logic [31:0] PERIPH_BASE = {PERIPH_REGION, 28'h0}
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic [31:0] ddata_w,
  input  logic        d_w,
  input  logic        d_r,
  output logic [31:0] ddata_r,
  output logic [31:0] gpio_out,
  output logic        irq
);

  localparam int AW = $clog2(RAM_WORDS);

  // Address decode
  logic        ram_sel;
  logic        per_sel;
  logic        aligned;
  logic        hit;
  logic        err_ev;
  logic        ram_we;
  logic        per_we;
  periph_reg_e reg_sel;
  logic [31:0] ram_rdata;
  logic [31:0] per_rdata;

  // Bits above the RAM index only alias inside the RAM region
  logic unused_addr;
  assign unused_addr = ^daddr[27:AW+2];

  assign ram_sel = (daddr[31:28] == RAM_BASE[31:28]);
  assign per_sel = (daddr[31:28] == PERIPH_BASE[31:28]);
  assign aligned = (daddr[1:0] == 2'b00);
  assign hit     = aligned & (ram_sel | per_sel);
  assign err_ev  = (d_r | d_w) & ~hit;
  assign ram_we  = d_w & hit & ram_sel;
  assign per_we  = d_w & hit & per_sel;
  assign reg_sel = periph_reg_e'(daddr[4:2]);

  // RAM writes are not gated by reset: the array has no reset
  dmem_ram #(
    .WORDS (RAM_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (daddr[AW+1:2]),
    .wdata_i (ddata_w),
    .rdata_o (ram_rdata)
  );

  // Peripheral registers
  logic [31:0] gpio_q, gpio_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] cmp_q, cmp_d;
  logic [1:0]  status_q, status_d;
  logic [1:0]  ctrl_q, ctrl_d;

  // Peripheral read mux; unimplemented offsets read zero
  always_comb begin
    per_rdata = 32'h0;
    case (reg_sel)
      REG_GPIO_OUT: per_rdata = gpio_q;
      REG_CNT:      per_rdata = cnt_q;
      REG_CMP:      per_rdata = cmp_q;
      REG_STATUS:   per_rdata = {30'h0, status_q};
      REG_CTRL:     per_rdata = {30'h0, ctrl_q};
      default:      per_rdata = 32'h0;
    endcase
  end

  // Zero-latency read data; bad or idle accesses return zero
  assign ddata_r = (d_r & hit) ? (ram_sel ? ram_rdata : per_rdata) : 32'h0;

  // Next-state for timer, CPU writes and sticky status flags
  always_comb begin
    logic       match_set;
    logic [1:0] w1c;
    gpio_d    = gpio_q;
    cnt_d     = cnt_q;
    cmp_d     = cmp_q;
    ctrl_d    = ctrl_q;
    match_set = 1'b0;
    w1c       = 2'b00;

    if (ctrl_q[CTRL_EN_BIT]) begin
      if (cnt_q == cmp_q) begin
        cnt_d     = 32'h0;
        match_set = 1'b1;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end

    if (per_we) begin
      case (reg_sel)
        REG_GPIO_OUT: gpio_d = ddata_w;
        REG_CNT: begin
          // CPU load overrides the timer and suppresses that cycle's match
          cnt_d     = ddata_w;
          match_set = 1'b0;
        end
        REG_CMP:    cmp_d  = ddata_w;
        REG_STATUS: w1c    = ddata_w[1:0];
        REG_CTRL:   ctrl_d = ddata_w[1:0];
        default:    ;
      endcase
    end

    // Set has priority over a same-cycle clear
    status_d = status_q & ~w1c;
    status_d[STATUS_MATCH_BIT] = status_d[STATUS_MATCH_BIT] | match_set;
    status_d[STATUS_ERR_BIT]   = status_d[STATUS_ERR_BIT] | err_ev;
  end

  // Register update with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!reset) begin
      gpio_q   <= 32'h0;
      cnt_q    <= 32'h0;
      cmp_q    <= 32'h0;
      status_q <= 2'b00;
      ctrl_q   <= 2'b00;
    end else begin
      gpio_q   <= gpio_d;
      cnt_q    <= cnt_d;
      cmp_q    <= cmp_d;
      status_q <= status_d;
      ctrl_q   <= ctrl_d;
    end
  end

  assign gpio_out = gpio_q;
  assign irq      = status_q[STATUS_MATCH_BIT] & ctrl_q[CTRL_IE_BIT];

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_responder
//  Purpose  : Directed, self-checking bench for data_mem_responder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] daddr = 32'h0;
  logic [31:0] ddata_w = 32'h0;
  logic        d_w = 1'b0;
  logic        d_r = 1'b0;
  logic [31:0] ddata_r;
  logic [31:0] gpio_out;
  logic        irq;

  data_mem_responder dut (
    .clk      (clk),
    .reset    (reset),
    .daddr    (daddr),
    .ddata_w  (ddata_w),
    .d_w      (d_w),
    .d_r      (d_r),
    .ddata_r  (ddata_r),
    .gpio_out (gpio_out),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] rd_s;

  typedef struct {
    logic        w;
    logic        r;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic [31:0] exp_gpio;
    logic        exp_irq;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One bus cycle: drive at negedge, capture comb read data, return after posedge
  task automatic cyc(input logic rn, input logic w, input logic r,
                     input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    reset   = rn;
    d_w     = w;
    d_r     = r;
    daddr   = a;
    ddata_w = wd;
    #1 rd_s = ddata_r;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wd);
    cyc(1'b1, 1'b1, 1'b0, a, wd);
  endtask

  task automatic rdchk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    cyc(1'b1, 1'b0, 1'b1, a, 32'h0);
    chk(nm, rd_s, exp);
  endtask

  localparam logic [31:0] GPIO = 32'h8000_0000;
  localparam logic [31:0] CNT  = 32'h8000_0004;
  localparam logic [31:0] CMP  = 32'h8000_0008;
  localparam logic [31:0] STAT = 32'h8000_000C;
  localparam logic [31:0] CTRL = 32'h8000_0010;

  initial begin
    //         w     r     addr           wdata          exp_rd         gpio           irq
    tbl[0]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h1111_1111, 32'h0,         32'h0,  1'b0};
    tbl[1]  = '{1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h1111_1111, 32'h0,  1'b0};
    tbl[2]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 32'h0,  1'b0};
    tbl[3]  = '{1'b1, 1'b0, 32'h0000_1014, 32'hCAFE_F00D, 32'h0,         32'h0,  1'b0};
    tbl[4]  = '{1'b0, 1'b1, 32'h0000_0014, 32'h0,         32'hCAFE_F00D, 32'h0,  1'b0};
    tbl[5]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'h0,         32'h0,  1'b0};
    tbl[6]  = '{1'b1, 1'b0, GPIO,          32'h0000_00A5, 32'h0,         32'hA5, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, GPIO,          32'h0,         32'h0000_00A5, 32'hA5, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, CMP,           32'h0000_1234, 32'h0,         32'hA5, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, CMP,           32'h0,         32'h0000_1234, 32'hA5, 1'b0};
    tbl[10] = '{1'b1, 1'b0, CTRL,          32'hFFFF_FFFC, 32'h0,         32'hA5, 1'b0};
    tbl[11] = '{1'b0, 1'b1, CTRL,          32'h0,         32'h0,         32'hA5, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 32'h8000_0014, 32'h0000_FFFF, 32'h0,         32'hA5, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 32'h8000_0014, 32'h0,         32'h0,         32'hA5, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 32'h8000_001C, 32'h0,         32'h0,         32'hA5, 1'b0};
    tbl[15] = '{1'b0, 1'b1, STAT,          32'h0,         32'h0,         32'hA5, 1'b0};

    // Reset state
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("reset_gpio", gpio_out, 32'h0);
    chk("reset_irq", {31'h0, irq}, 32'h0);
    rdchk("reset_cnt", CNT, 32'h0);

    // Table: RAM access, aliasing, GPIO, register masking, unmapped offsets
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].wd);
      chk($sformatf("vec%0d_rd", i), rd_s, tbl[i].exp_rd);
      chk($sformatf("vec%0d_gpio", i), gpio_out, tbl[i].exp_gpio);
      chk($sformatf("vec%0d_irq", i), {31'h0, irq}, {31'h0, tbl[i].exp_irq});
    end

    // Reset mid-operation: peripheral write dropped, RAM write kept
    cyc(1'b0, 1'b1, 1'b0, GPIO, 32'h0000_0077);
    chk("rst_gpio_clear", gpio_out, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0000_0018, 32'h5555_AAAA);
    rdchk("rst_ram_keep", 32'h0000_0010, 32'hDEAD_BEEF);
    rdchk("rst_ram_write", 32'h0000_0018, 32'h5555_AAAA);
    rdchk("rst_cmp_clear", CMP, 32'h0);

    // Timer match: CMP=3, CNT=0, en+ie
    wr(CMP, 32'd3);
    wr(CNT, 32'd0);
    wr(CTRL, 32'h3);
    rdchk("tmr_cnt0", CNT, 32'd0);
    rdchk("tmr_cnt1", CNT, 32'd1);
    rdchk("tmr_cnt2", CNT, 32'd2);
    chk("tmr_irq_pre", {31'h0, irq}, 32'h0);
    rdchk("tmr_cnt3", CNT, 32'd3);
    chk("tmr_irq_set", {31'h0, irq}, 32'h1);
    rdchk("tmr_cnt_wrap0", CNT, 32'd0);
    rdchk("tmr_status", STAT, 32'h1);          // CNT 1 -> 2
    wr(STAT, 32'h1);                           // CNT 2 -> 3, match cleared
    chk("w1c_irq_clear", {31'h0, irq}, 32'h0);
    wr(STAT, 32'h1);                           // CNT == CMP: set beats clear
    chk("w1c_vs_set_irq", {31'h0, irq}, 32'h1);
    rdchk("w1c_vs_set_stat", STAT, 32'h1);     // CNT 0 -> 1
    wr(STAT, 32'h1);                           // CNT 1 -> 2
    chk("w1c_irq_clear2", {31'h0, irq}, 32'h0);
    rdchk("tmr_cnt_pre_ld", CNT, 32'd2);       // CNT 2 -> 3
    // CPU load on the match cycle wins; read still shows the old count
    cyc(1'b1, 1'b1, 1'b1, CNT, 32'd100);
    chk("ld_old_read", rd_s, 32'd3);
    chk("ld_no_match_irq", {31'h0, irq}, 32'h0);
    rdchk("ld_cnt", CNT, 32'd100);             // 100 -> 101
    rdchk("ld_no_match_stat", STAT, 32'h0);    // 101 -> 102
    wr(CTRL, 32'h0);                           // still counts this cycle: 102 -> 103
    rdchk("dis_cnt", CNT, 32'd103);
    rdchk("dis_cnt_hold", CNT, 32'd103);

    // Errors: misaligned and unmapped accesses
    wr(GPIO, 32'h0000_003C);
    rdchk("err_misal_rd", 32'h0000_0006, 32'h0);
    rdchk("err_stat", STAT, 32'h2);
    wr(STAT, 32'h2);
    rdchk("err_clear", STAT, 32'h0);
    wr(32'h4000_0000, 32'h0000_0999);
    rdchk("err_unmapped_stat", STAT, 32'h2);
    chk("err_unmapped_gpio", gpio_out, 32'h0000_003C);
    wr(GPIO | 32'h1, 32'h0000_00FF);
    chk("err_misal_gpio", gpio_out, 32'h0000_003C);
    wr(32'h0000_0011, 32'h0);
    rdchk("err_misal_ram", 32'h0000_0010, 32'hDEAD_BEEF);
    rdchk("err_unmapped_rd", 32'h4000_0000, 32'h0);

    // Timer wrap at 2^32-1
    wr(STAT, 32'h3);
    wr(CMP, 32'hFFFF_FFFF);
    wr(CNT, 32'hFFFF_FFFE);
    wr(CTRL, 32'h3);
    rdchk("wrap_cnt_fe", CNT, 32'hFFFF_FFFE);
    chk("wrap_irq_pre", {31'h0, irq}, 32'h0);
    rdchk("wrap_cnt_ff", CNT, 32'hFFFF_FFFF);
    chk("wrap_irq_set", {31'h0, irq}, 32'h1);
    rdchk("wrap_cnt_0", CNT, 32'h0);
    rdchk("wrap_unmapped_reg7", 32'h8000_001C, 32'h0);
    wr(CTRL, 32'h1);
    chk("ie_off_irq", {31'h0, irq}, 32'h0);
    rdchk("ie_off_stat", STAT, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
